// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit framer/serializer. Accepts one byte per valid/ready
//   handshake and sends: start bit, 5..8 LSB-first data bits, an optional
//   even/odd parity bit, then 1 or 2 stop bits. Every serial bit lasts
//   max(clk_div, 1) clock cycles. The frame configuration is captured at
//   accept, so changing the inputs mid-frame has no effect.
//
// Ports
//   clk_i          system clock (rising edge)
//   arst_ni        asynchronous active-low reset
//   clk_div_i      clocks per serial bit (0 behaves as 1)
//   data_size_i    data bits per frame: 00=5, 01=6, 10=7, 11=8
//   parity_en_i    1 inserts a parity bit after the data bits
//   parity_type_i  0 = even, 1 = odd
//   double_stop_i  0 = one stop bit, 1 = two stop bits
//   data_i         byte to send (bits above the data size are ignored)
//   data_valid_i   data_i is valid
//   data_ready_o   block can accept a byte (IDLE only)
//   tx_o           registered serial line, idle high
//   busy_o         a frame is in progress
module uart_tx_serializer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    input  logic [1:0]           data_size_i,
    input  logic                 parity_en_i,
    input  logic                 parity_type_i,
    input  logic                 double_stop_i,
    input  logic [7:0]           data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_WIDTH-1:0] last_cnt;
    logic [1:0]           size_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 dstop_q;
    logic [7:0]           shreg_q, shreg_d;
    logic [2:0]           data_cnt_q, data_cnt_d;
    logic [2:0]           last_data;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 accept;
    logic                 bit_end;

    // Zero the bits above the configured data size, matching the receive-side
    // checker so both ends agree on which bits the parity covers.
    function automatic logic [7:0] mask_data(input logic [7:0] d, input logic [1:0] size);
        logic [7:0] m;
        m    = d;
        m[5] = d[5] & (size != 2'b00);
        m[6] = d[6] & size[1];
        m[7] = d[7] & (size == 2'b11);
        return m;
    endfunction

    // Even parity is the XOR of the used bits; odd parity is its inverse.
    function automatic logic parity_of(input logic [7:0] d, input logic [1:0] size,
                                       input logic odd);
        return (^mask_data(d, size)) ^ odd;
    endfunction

    assign data_ready_o = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign tx_o         = tx_q;
    assign accept       = data_valid_i && (state_q == S_IDLE);

    // A divisor of 0 behaves like 1: every count is then the last one.
    assign last_cnt  = (div_q == '0) ? '0 : div_q - DIV_WIDTH'(1);
    assign bit_end   = (bit_cnt_q == last_cnt);
    assign last_data = 3'd4 + {1'b0, size_q};

    // tx_d is the line level for the state being entered, so the line is
    // registered yet changes on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_cnt_d = data_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;

        if (state_q != S_IDLE) begin
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d    = S_START;
                    tx_d       = 1'b0;
                    bit_cnt_d  = '0;
                    shreg_d    = data_i;
                    data_cnt_d = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (data_cnt_q == last_data) begin
                        data_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        data_cnt_d = data_cnt_q + 3'd1;
                        tx_d       = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop_cnt_q == dstop_q) begin
                        state_d    = S_IDLE;
                        stop_cnt_d = 1'b0;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_cnt_q <= '0;
            stop_cnt_q <= 1'b0;
            div_q      <= '0;
            size_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            dstop_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_cnt_q <= data_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            if (accept) begin
                div_q     <= clk_div_i;
                size_q    <= data_size_i;
                par_en_q  <= parity_en_i;
                par_bit_q <= parity_of(data_i, data_size_i, parity_type_i);
                dstop_q   <= double_stop_i;
            end
        end
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit-side UART framer and serializer that pairs with the receive-side parity checker. It accepts one byte per valid/ready handshake and emits a start bit, 5–8 LSB-first data bits, an optional even/odd parity bit and 1 or 2 stop bits on `tx_o`. Each bit lasts a programmable number of clock cycles. It sits between the TX FIFO and the pad.

## Interface
- `DIV_WIDTH`, default 16: width of the clocks-per-bit divisor.
- `clk_i`  input  1  system clock; all logic on the rising edge.
- `arst_ni`  input  1  reset, asynchronous and active-low.
- `clk_div_i`  input  DIV_WIDTH  clock cycles per serial bit; 0 is treated as 1.
- `data_size_i`  input  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
- `parity_en_i`  input  1  1 inserts a parity bit after the data bits.
- `parity_type_i`  input  1  0=even, 1=odd.
- `double_stop_i`  input  1  0 gives 1 stop bit, 1 gives 2 stop bits.
- `data_i`  input  8  byte to send; bits above the data size are ignored.
- `data_valid_i`  input  1  `data_i` is valid.
- `data_ready_o`  output  1  block can accept a byte.
- `tx_o`  output  1  serial line, idle high; registered output.
- `busy_o`  output  1  a frame is in progress.

## Operation
- Handshake: a byte is accepted on a rising edge where `data_valid_i` and `data_ready_o` are both 1.
- `data_ready_o` equals 1 only in IDLE and is driven combinationally from state.
- At accept, the block latches `data_i`, `clk_div_i`, `data_size_i`, `parity_en_i`, `parity_type_i` and `double_stop_i`. Changes to these inputs mid-frame have no effect on the current frame.
- Parity is computed at accept over the used bits only. Unused upper bits are masked to 0 using the same rule as the checker:
  - bit5 is used when size≠00.
  - bit6 is used when size[1] is 1.
  - bit7 is used when size is 11.
- Parity bit value:
  - Even: XOR of the masked bits, so the total count of 1s is even.
  - Odd: the inverse of the even value.
- FSM states: IDLE → START → DATA → (PARITY if enabled) → STOP → IDLE.
  - IDLE: `tx_o`=1, `busy_o`=0.
  - START: `tx_o`=0.
  - DATA: `tx_o` = shift register LSB; shifts right at the end of each bit period.
  - PARITY: `tx_o` = latched parity bit.
  - STOP: `tx_o`=1 for 1 or 2 bit periods.
- Bit-period counter counts 0..D−1, where D = max(latched `clk_div`, 1). The bit ends when the count reaches D−1; the counter then wraps to 0.
- Data-bit counter counts 0..N−1, where N = 5 + `data_size`. DATA exits after bit N−1.
- Stop-bit counter counts 1 or 2 periods.
- `busy_o` equals 1 in every state except IDLE.

## Timing
- Reset (asynchronous assert, synchronous release to the clock): state=IDLE, `tx_o`=1, `busy_o`=0, `data_ready_o`=1, all counters and registers 0.
- Accept at edge k:
  - `tx_o` goes to 0 and `busy_o` to 1 after edge k (visible in cycle k+1).
  - Each bit is held for exactly D cycles.
- Frame length: F = (1 + N + P + S)·D cycles, where P = `parity_en` and S = 1 + `double_stop`.
- End of frame: the last stop period ends at edge k+F. The FSM is in IDLE in the cycle after that edge, with `data_ready_o`=1 and `tx_o` still 1.
- Back-to-back frames: a byte offered continuously is accepted on the edge at the end of the first IDLE cycle. Consecutive frames are therefore separated by exactly one extra idle-high cycle.
- Reset mid-frame: asserting reset forces `tx_o`=1 and returns to IDLE immediately, without waiting for a clock edge. The partial frame is discarded and is not resumed.
- Valid without ready: while busy the byte is not consumed. The source must hold `data_valid_i` and `data_i` until accepted.

## Test plan
- 8N1, D=4, `data_i`=0x55 → `tx_o` sequence 0,1,0,1,0,1,0,1,0,1, each bit for 4 cycles. `busy_o` high for 40 cycles; `data_ready_o` returns in cycle k+41.
- 5 bits, even parity, D=2, `data_i`=0xFF → bits 0,1,1,1,1,1, parity 1, stop 1 (16 cycles). Bits 7:5 are ignored: `data_i`=0x1F gives an identical waveform.
- 7 bits, odd parity, 2 stop, D=3, `data_i`=0x83 → data 1,1,0,0,0,0,0, then parity 1, then stop 1,1. Total 33 cycles; bit7 excluded from parity.
- `clk_div_i`=0, 6N1, `data_i`=0x2A → each bit lasts 1 cycle, sequence 0,0,1,0,1,0,1,1. Changing `clk_div_i` mid-frame has no effect.
- Back-to-back: `data_valid_i` held high with 0xA5 then 0x3C → frames separated by exactly one idle-high cycle. No byte is dropped or duplicated.
- Reset asserted in the 3rd data bit → `tx_o`=1, `busy_o`=0 and `data_ready_o`=1 immediately. The next accepted byte produces a clean full frame.
